// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage ALU with iterative multiply/divide and HI/LO registers.
// Single-cycle ops return one cycle after accept. MULT/MULTU/DIV/DIVU take
// WIDTH+1 cycles, and the unit holds in_ready low until they finish.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int CTL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CTL_W-1:0] alu_ctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] C,
  output logic             zero,
  output logic             positive,
  output logic             overflow,
  output logic             signed_less,
  output logic             div_by_zero,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(WIDTH);

  localparam logic [CTL_W-1:0] OP_ADD   = CTL_W'(0);
  localparam logic [CTL_W-1:0] OP_SUB   = CTL_W'(1);
  localparam logic [CTL_W-1:0] OP_OR    = CTL_W'(2);
  localparam logic [CTL_W-1:0] OP_LUI   = CTL_W'(3);
  localparam logic [CTL_W-1:0] OP_AND   = CTL_W'(4);
  localparam logic [CTL_W-1:0] OP_XOR   = CTL_W'(5);
  localparam logic [CTL_W-1:0] OP_SLT   = CTL_W'(6);
  localparam logic [CTL_W-1:0] OP_SLTU  = CTL_W'(7);
  localparam logic [CTL_W-1:0] OP_MULT  = CTL_W'(8);
  localparam logic [CTL_W-1:0] OP_MULTU = CTL_W'(9);
  localparam logic [CTL_W-1:0] OP_DIV   = CTL_W'(10);
  localparam logic [CTL_W-1:0] OP_DIVU  = CTL_W'(11);
  localparam logic [CTL_W-1:0] OP_MFHI  = CTL_W'(12);
  localparam logic [CTL_W-1:0] OP_MFLO  = CTL_W'(13);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;   // current multi-cycle op is a divide
  logic             dz;       // current divide has a zero divisor
  logic             neg_p;    // negate product / quotient at the end
  logic             neg_r;    // negate remainder at the end
  logic [WIDTH-1:0] a_raw;    // original A, returned in hi on divide-by-zero
  logic [WIDTH-1:0] op_a;     // multiplicand magnitude
  logic [WIDTH-1:0] op_b;     // divisor magnitude
  logic [WIDTH-1:0] p_hi;     // product high half / partial remainder
  logic [WIDTH-1:0] p_lo;     // multiplier bits / dividend-quotient shifter

  // Single-cycle result and overflow
  logic [WIDTH-1:0] sum, diff, res;
  logic             ovf;
  always_comb begin
    sum  = A + B;
    diff = A - B;
    res  = '0;
    ovf  = 1'b0;
    case (alu_ctl)
      OP_ADD: begin
        res = sum;
        ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res = diff;
        ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_OR:   res = A | B;
      OP_LUI:  res = {B[HALF-1:0], {HALF{1'b0}}};
      OP_AND:  res = A & B;
      OP_XOR:  res = A ^ B;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_MFHI: res = hi;
      OP_MFLO: res = lo;
      default: res = '0;
    endcase
  end

  // Operand magnitudes at accept; signs only matter for MULT/DIV
  logic             sgn_op, sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  always_comb begin
    sgn_op = (alu_ctl == OP_MULT) || (alu_ctl == OP_DIV);
    sgn_a  = sgn_op & A[WIDTH-1];
    sgn_b  = sgn_op & B[WIDTH-1];
    mag_a  = sgn_a ? -A : A;
    mag_b  = sgn_b ? -B : B;
  end

  // One shift-add step and one restoring-divide step
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_trial;
  always_comb begin
    mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, op_a} : {(WIDTH+1){1'b0}});
    div_trial = {1'b0, p_hi, p_lo[WIDTH-1]} - {2'b00, op_b};
  end

  // Sign fix-up of the finished magnitudes
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_hi, fin_lo;
  always_comb begin
    prod   = {p_hi, p_lo};
    fin_hi = '0;
    fin_lo = '0;
    if (!is_div) begin
      {fin_hi, fin_lo} = neg_p ? -prod : prod;
    end else if (dz) begin
      fin_hi = a_raw;
      fin_lo = '1;
    end else begin
      fin_lo = neg_p ? -p_lo : p_lo;
      fin_hi = neg_r ? -p_hi : p_hi;
    end
  end

  assign in_ready = !busy;

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      dz          <= 1'b0;
      neg_p       <= 1'b0;
      neg_r       <= 1'b0;
      a_raw       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      p_hi        <= '0;
      p_lo        <= '0;
      out_valid   <= 1'b0;
      C           <= '0;
      zero        <= 1'b0;
      positive    <= 1'b0;
      overflow    <= 1'b0;
      signed_less <= 1'b0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            signed_less <= ($signed(A) < $signed(B));
            case (alu_ctl)
              OP_MULT, OP_MULTU: begin
                state  <= S_MUL;
                busy   <= 1'b1;
                cnt    <= '0;
                is_div <= 1'b0;
                dz     <= 1'b0;
                neg_p  <= sgn_a ^ sgn_b;
                neg_r  <= 1'b0;
                a_raw  <= A;
                op_a   <= mag_a;
                op_b   <= mag_b;
                p_hi   <= '0;
                p_lo   <= mag_b;
              end
              OP_DIV, OP_DIVU: begin
                state  <= S_DIV;
                busy   <= 1'b1;
                cnt    <= '0;
                is_div <= 1'b1;
                dz     <= (B == '0);
                neg_p  <= sgn_a ^ sgn_b;
                neg_r  <= sgn_a;
                a_raw  <= A;
                op_a   <= mag_a;
                op_b   <= mag_b;
                p_hi   <= '0;
                p_lo   <= mag_a;
              end
              default: begin
                C         <= res;
                zero      <= (res == '0);
                positive  <= !res[WIDTH-1] && (res != '0);
                overflow  <= ovf;
                out_valid <= 1'b1;
              end
            endcase
          end
        end
        S_MUL: begin
          p_hi <= mul_sum[WIDTH:1];
          p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) state <= S_DONE;
        end
        S_DIV: begin
          // A zero divisor just burns the same number of cycles
          if (!dz) begin
            if (!div_trial[WIDTH+1]) begin
              p_hi <= div_trial[WIDTH-1:0];
              p_lo <= {p_lo[WIDTH-2:0], 1'b1};
            end else begin
              p_hi <= {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
              p_lo <= {p_lo[WIDTH-2:0], 1'b0};
            end
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) state <= S_DONE;
        end
        S_DONE: begin
          hi        <= fin_hi;
          lo        <= fin_lo;
          C         <= fin_lo;
          zero      <= (fin_lo == '0);
          positive  <= !fin_lo[WIDTH-1] && (fin_lo != '0);
          overflow  <= 1'b0;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          if (is_div) div_by_zero <= dz;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
